// File: rtl/pkt_write_control.sv
// pkt_write_control: ingress writer for the centralized packet buffer.
// Allocates a free buffer ID per packet, writes every word at {bufid, offset},
// and hands a {bufid, byte length} descriptor to the lookup stage on the tail.
// A packet is dropped when no buffer is free, when the descriptor slot is
// still occupied, or when it would not fit in one buffer (a full 128-word
// packet of 2048 bytes is also an overrun: 2048 cannot be encoded in 11 bits).
module pkt_write_control (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [133:0] iv_pkt_data,
  input  logic         i_pkt_data_wr,
  input  logic [8:0]   iv_free_bufid,
  input  logic         i_free_bufid_empty,
  output logic         o_free_bufid_rd,
  output logic [133:0] ov_pkt_data,
  output logic [15:0]  ov_pkt_waddr,
  output logic         o_pkt_wr,
  output logic [8:0]   ov_pkt_bufid,
  output logic [10:0]  ov_pkt_len,
  output logic         o_pkt_bufid_wr,
  input  logic         i_pkt_bufid_ack,
  output logic [8:0]   ov_release_bufid,
  output logic         o_release_bufid_wr,
  output logic         o_pkt_discard_pulse,
  output logic [1:0]   ov_pwc_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DISCARD = 2'd2} state_t;

  state_t       state_reg, state_next;
  logic [8:0]   bufid_reg, bufid_next;
  logic [6:0]   offset_reg, offset_next;
  logic         pkt_wr_reg, pkt_wr_next;
  logic [133:0] pkt_data_reg, pkt_data_next;
  logic [15:0]  waddr_reg, waddr_next;
  logic         desc_pend_reg, desc_pend_next;
  logic [8:0]   desc_bufid_reg, desc_bufid_next;
  logic [10:0]  desc_len_reg, desc_len_next;
  logic         desc_wr_reg;
  logic         rel_wr_reg, rel_wr_next;
  logic [8:0]   rel_bufid_reg, rel_bufid_next;
  logic         discard_reg, discard_next;
  logic         free_rd;
  logic         take_head;

  logic [1:0]   word_type;
  logic [3:0]   word_inv;
  logic         is_head, is_body, is_tail;
  logic         slot_busy, can_alloc;
  logic [7:0]   len_words;
  logic [11:0]  len_full;
  logic         tail_overrun;

  assign word_type = iv_pkt_data[133:132];
  assign word_inv  = iv_pkt_data[131:128];
  assign is_head   = i_pkt_data_wr && (word_type == 2'b01);
  assign is_body   = i_pkt_data_wr && (word_type == 2'b11);
  assign is_tail   = i_pkt_data_wr && (word_type == 2'b10);

  // A descriptor waiting to be raised also counts as an occupied slot.
  assign slot_busy = desc_wr_reg | desc_pend_reg;
  assign can_alloc = !i_free_bufid_empty && !slot_busy;

  // Byte length uses the offset before the tail's increment.
  assign len_words    = {1'b0, offset_reg} + 8'd2;
  assign len_full     = {len_words, 4'b0000} - {8'd0, word_inv};
  assign tail_overrun = (offset_reg == 7'd126) && (word_inv == 4'd0);

  // Next-state and registered-output decode for the packet FSM.
  always_comb begin
    state_next      = state_reg;
    bufid_next      = bufid_reg;
    offset_next     = offset_reg;
    pkt_wr_next     = 1'b0;
    pkt_data_next   = pkt_data_reg;
    waddr_next      = waddr_reg;
    desc_pend_next  = 1'b0;
    desc_bufid_next = desc_bufid_reg;
    desc_len_next   = desc_len_reg;
    rel_wr_next     = 1'b0;
    rel_bufid_next  = rel_bufid_reg;
    discard_next    = 1'b0;
    free_rd         = 1'b0;
    take_head       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_head) take_head = 1'b1;
      end
      WRITE: begin
        if (is_head) begin
          // Tail was lost: give the buffer back, then treat as a fresh head.
          rel_wr_next    = 1'b1;
          rel_bufid_next = bufid_reg;
          discard_next   = 1'b1;
          take_head      = 1'b1;
        end else if (is_body || is_tail) begin
          if ((offset_reg == 7'd127) || (is_tail && tail_overrun)) begin
            rel_wr_next    = 1'b1;
            rel_bufid_next = bufid_reg;
            discard_next   = 1'b1;
            state_next     = is_tail ? IDLE : DISCARD;
          end else begin
            pkt_wr_next   = 1'b1;
            pkt_data_next = iv_pkt_data;
            offset_next   = offset_reg + 7'd1;
            waddr_next    = {bufid_reg, offset_reg + 7'd1};
            if (is_tail) begin
              desc_pend_next  = 1'b1;
              desc_bufid_next = bufid_reg;
              desc_len_next   = len_full[10:0];
              state_next      = IDLE;
            end
          end
        end
      end
      DISCARD: begin
        if (is_head) take_head = 1'b1;
        else if (is_tail) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (take_head) begin
      if (can_alloc) begin
        free_rd       = 1'b1;
        bufid_next    = iv_free_bufid;
        offset_next   = 7'd0;
        pkt_wr_next   = 1'b1;
        pkt_data_next = iv_pkt_data;
        waddr_next    = {iv_free_bufid, 7'd0};
        state_next    = WRITE;
      end else begin
        discard_next = 1'b1;
        state_next   = DISCARD;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      bufid_reg      <= 9'd0;
      offset_reg     <= 7'd0;
      pkt_wr_reg     <= 1'b0;
      pkt_data_reg   <= 134'd0;
      waddr_reg      <= 16'd0;
      desc_pend_reg  <= 1'b0;
      desc_bufid_reg <= 9'd0;
      desc_len_reg   <= 11'd0;
      rel_wr_reg     <= 1'b0;
      rel_bufid_reg  <= 9'd0;
      discard_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bufid_reg      <= bufid_next;
      offset_reg     <= offset_next;
      pkt_wr_reg     <= pkt_wr_next;
      pkt_data_reg   <= pkt_data_next;
      waddr_reg      <= waddr_next;
      desc_pend_reg  <= desc_pend_next;
      desc_bufid_reg <= desc_bufid_next;
      desc_len_reg   <= desc_len_next;
      rel_wr_reg     <= rel_wr_next;
      rel_bufid_reg  <= rel_bufid_next;
      discard_reg    <= discard_next;
    end
  end

  // Descriptor valid: raised one cycle after loading, held until acknowledged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      desc_wr_reg <= 1'b0;
    end else if (desc_pend_reg) begin
      desc_wr_reg <= 1'b1;
    end else if (desc_wr_reg && i_pkt_bufid_ack) begin
      desc_wr_reg <= 1'b0;
    end
  end

  assign o_free_bufid_rd     = free_rd & i_rst_n;
  assign ov_pkt_data         = pkt_data_reg;
  assign ov_pkt_waddr        = waddr_reg;
  assign o_pkt_wr            = pkt_wr_reg;
  assign ov_pkt_bufid        = desc_bufid_reg;
  assign ov_pkt_len          = desc_len_reg;
  assign o_pkt_bufid_wr      = desc_wr_reg;
  assign ov_release_bufid    = rel_bufid_reg;
  assign o_release_bufid_wr  = rel_wr_reg;
  assign o_pkt_discard_pulse = discard_reg;
  assign ov_pwc_state        = state_reg;

endmodule
